multicycle_controller: RTL and testbench

//  Multi-cycle RV32I main controller: successor to the single-cycle opcode decoder. Owns the FETCH/DECODE/EXEC/MEM/WB FSM.

---
 rtl/multicycle_controller.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main controller: FETCH/DECODE/EXEC/MEM/WB sequencer with bounded memory waits.
// Optional: define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes (cause 11) instead of retiring them as NOPs.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             dmem_w_en,
  output logic             ir_w_en,
  output logic             pc_w_en,
  output logic             reg_w_en,
  output logic [1:0]       reg_w_sel,
  output logic             reg_imm_sel,
  output logic [2:0]       imm_sel,
  output logic             rs1_pc_sel,
  output logic             jump_en,
  output logic             branch_en,
  output logic [2:0]       funct3,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_U = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_S = 3'b011;
  localparam logic [2:0] IMM_B = 3'b100;

  localparam logic [1:0] WSEL_DMEM = 2'b00;
  localparam logic [1:0] WSEL_ALU  = 2'b01;
  localparam logic [1:0] WSEL_PC4  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_IMEM    = 2'b01;
  localparam logic [1:0] CAUSE_DMEM    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

  localparam bit          TIMEOUT_ON = (MEM_TIMEOUT > 0);
  localparam int          CW         = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL   = CW'(MEM_TIMEOUT);

  state_t        state, state_next;
  logic [31:0]   ir;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    cause_next;
  logic          waiting, timeout_hit;

  logic [1:0] dec_w_sel;
  logic [2:0] dec_imm_sel;
  logic       dec_b_imm, dec_a_pc;
  logic       is_load, is_store, is_branch, is_jump, is_legal;

  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[31:15], ir[11:7]};

  assign funct3    = ir[14:12];
  assign trap      = (state == TRAP);
  assign state_dbg = state;

  // Opcode decode of the latched IR; unknown opcodes decode to all-zero selects.
  always_comb begin
    dec_w_sel   = WSEL_DMEM;
    dec_imm_sel = IMM_U;
    dec_b_imm   = 1'b0;
    dec_a_pc    = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_branch   = 1'b0;
    is_jump     = 1'b0;
    is_legal    = 1'b1;
    case (ir[6:0])
      OP_LOAD:   begin is_load = 1'b1; dec_b_imm = 1'b1; dec_imm_sel = IMM_I; end
      OP_STORE:  begin is_store = 1'b1; dec_b_imm = 1'b1; dec_imm_sel = IMM_S; end
      OP_BRANCH: begin is_branch = 1'b1; dec_imm_sel = IMM_B; end
      OP_OP:     dec_w_sel = WSEL_ALU;
      OP_IMM:    begin dec_w_sel = WSEL_ALU; dec_b_imm = 1'b1; dec_imm_sel = IMM_I; end
      OP_LUI:    begin dec_w_sel = WSEL_ALU; dec_b_imm = 1'b1; end
      OP_AUIPC:  begin dec_w_sel = WSEL_ALU; dec_b_imm = 1'b1; dec_a_pc = 1'b1; end
      OP_JAL:    begin
        dec_w_sel = WSEL_PC4; dec_b_imm = 1'b1; dec_imm_sel = IMM_J;
        dec_a_pc = 1'b1; is_jump = 1'b1;
      end
      OP_JALR:   begin
        dec_w_sel = WSEL_PC4; dec_b_imm = 1'b1; dec_imm_sel = IMM_I; is_jump = 1'b1;
      end
      default:   is_legal = 1'b0;
    endcase
  end

  // Handshake: a req stays high until the cycle its ack is seen; that cycle
  // completes the transfer. An ack with no pending req is ignored.
  assign waiting     = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
  assign timeout_hit = TIMEOUT_ON && (wait_cnt == TO_VAL);

  always_comb begin
    state_next  = state;
    cause_next  = trap_cause;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_w_en   = 1'b0;
    ir_w_en     = 1'b0;
    pc_w_en     = 1'b0;
    reg_w_en    = 1'b0;
    jump_en     = 1'b0;
    branch_en   = 1'b0;
    reg_w_sel   = WSEL_DMEM;
    reg_imm_sel = 1'b0;
    imm_sel     = IMM_U;
    rs1_pc_sel  = 1'b0;
    case (state)
      FETCH: begin
        // Fetch is held off while reset is asserted so the first req is a fresh one.
        imem_req = !rst;
        if (imem_req && imem_ack) begin
          ir_w_en    = 1'b1;
          state_next = DECODE;
        end else if (timeout_hit) begin
          state_next = TRAP;
          cause_next = CAUSE_IMEM;
        end
      end
      DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!is_legal) begin
          state_next = TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else begin
          state_next = EXEC;
        end
`else
        state_next = EXEC;
`endif
      end
      EXEC: begin
        if (is_load || is_store) begin
          state_next = MEM;
        end else if (is_branch) begin
          branch_en  = 1'b1;
          pc_w_en    = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        dmem_req  = 1'b1;
        dmem_w_en = is_store;
        if (dmem_ack) begin
          pc_w_en    = is_store;
          state_next = is_store ? FETCH : WB;
        end else if (timeout_hit) begin
          state_next = TRAP;
          cause_next = CAUSE_DMEM;
        end
      end
      WB: begin
        reg_w_en   = is_legal;
        pc_w_en    = 1'b1;
        jump_en    = is_jump;
        state_next = FETCH;
      end
      default: state_next = TRAP;
    endcase
    if (state inside {DECODE, EXEC, MEM, WB}) begin
      reg_w_sel   = dec_w_sel;
      reg_imm_sel = dec_b_imm;
      imm_sel     = dec_imm_sel;
      rs1_pc_sel  = dec_a_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      ir         <= '0;
      wait_cnt   <= '0;
      instret    <= '0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state      <= state_next;
      trap_cause <= cause_next;
      if (ir_w_en) ir <= instr;
      if (pc_w_en) instret <= instret + CNT_W'(1);
      // With the timeout disabled the counter stays at zero rather than wrapping.
      if (state_next != state || !waiting) wait_cnt <= '0;
      else if (TIMEOUT_ON) wait_cnt <= wait_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: vector table per instruction class plus timeout/reset/illegal sequences.
module tb_multicycle_controller;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [1:0] K_WB    = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;
  localparam logic [1:0] K_BR    = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        imem_req, imem_ack, dmem_req, dmem_ack, dmem_w_en;
  logic        ir_w_en, pc_w_en, reg_w_en, reg_imm_sel, rs1_pc_sel, jump_en, branch_en, trap;
  logic [1:0]  reg_w_sel, trap_cause;
  logic [2:0]  imm_sel, funct3, state_dbg;
  logic [31:0] instret;

  typedef struct {
    logic [31:0] instr;
    int          imem_dly;
    int          dmem_dly;
    logic [1:0]  kind;
    logic [1:0]  wsel;
    logic [2:0]  imm;
    logic        rimm;
    logic        rs1pc;
    logic        regw;
    logic        jump;
    logic        wsel_dc;
    logic        imm_dc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_instret;
  int          n_tests = 0;
  int          n_fail  = 0;

  multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .dmem_w_en(dmem_w_en),
    .ir_w_en(ir_w_en), .pc_w_en(pc_w_en), .reg_w_en(reg_w_en),
    .reg_w_sel(reg_w_sel), .reg_imm_sel(reg_imm_sel), .imm_sel(imm_sel),
    .rs1_pc_sel(rs1_pc_sel), .jump_en(jump_en), .branch_en(branch_en),
    .funct3(funct3), .trap(trap), .trap_cause(trap_cause),
    .instret(instret), .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Scoreboard check
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic retire_check();
    exp_instret = exp_instret + 32'd1;
    exp_q.push_back(exp_instret);
  endtask

  task automatic check_instret(input string name);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_instret;
    check(name, instret, e);
  endtask

  // Drivers
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    exp_instret = 32'd0;
    check("rst_instret", instret, 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_cause", 32'(trap_cause), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
  endtask

  task automatic drive_fetch(input logic [31:0] ins);
    imem_ack = 1'b1; instr = ins;
    @(negedge clk);
    imem_ack = 1'b0; instr = 32'hdead_beef;
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.imem_dly; i++) begin
      imem_ack = 1'b0; #1;
      check("fetch_wait_state", 32'(state_dbg), 32'(ST_FETCH));
      check("fetch_wait_req", 32'(imem_req), 32'd1);
      check("fetch_wait_ir_w_en", 32'(ir_w_en), 32'd0);
      @(negedge clk);
    end
    imem_ack = 1'b1; instr = v.instr; #1;
    check("fetch_ack_state", 32'(state_dbg), 32'(ST_FETCH));
    check("fetch_ir_w_en", 32'(ir_w_en), 32'd1);
    check("fetch_trap", 32'(trap), 32'd0);
    @(negedge clk);
    imem_ack = 1'b0; instr = 32'hdead_beef; #1;
    check("decode_state", 32'(state_dbg), 32'(ST_DECODE));
    check("decode_imem_req", 32'(imem_req), 32'd0);
    check("decode_funct3", 32'(funct3), 32'(v.instr[14:12]));
    check("decode_reg_imm_sel", 32'(reg_imm_sel), 32'(v.rimm));
    check("decode_rs1_pc_sel", 32'(rs1_pc_sel), 32'(v.rs1pc));
    if (!v.imm_dc) check("decode_imm_sel", 32'(imm_sel), 32'(v.imm));
    if (!v.wsel_dc) check("decode_reg_w_sel", 32'(reg_w_sel), 32'(v.wsel));
    @(negedge clk); #1;
    check("exec_state", 32'(state_dbg), 32'(ST_EXEC));
    check("exec_branch_en", 32'(branch_en), 32'(v.kind == K_BR));
    check("exec_pc_w_en", 32'(pc_w_en), 32'(v.kind == K_BR));
    check("exec_reg_w_en", 32'(reg_w_en), 32'd0);
    if (v.kind == K_BR) retire_check();
    @(negedge clk);
    if (v.kind == K_LOAD || v.kind == K_STORE) begin
      for (int i = 0; i <= v.dmem_dly; i++) begin
        dmem_ack = (i == v.dmem_dly); #1;
        check("mem_state", 32'(state_dbg), 32'(ST_MEM));
        check("mem_dmem_req", 32'(dmem_req), 32'd1);
        check("mem_dmem_w_en", 32'(dmem_w_en), 32'(v.kind == K_STORE));
        check("mem_reg_w_en", 32'(reg_w_en), 32'd0);
        check("mem_pc_w_en", 32'(pc_w_en), 32'(dmem_ack && v.kind == K_STORE));
        check("mem_imm_sel", 32'(imm_sel), 32'(v.imm));
        @(negedge clk);
      end
      dmem_ack = 1'b0;
      if (v.kind == K_STORE) retire_check();
    end
    if (v.kind == K_WB || v.kind == K_LOAD) begin
      #1;
      check("wb_state", 32'(state_dbg), 32'(ST_WB));
      check("wb_reg_w_en", 32'(reg_w_en), 32'(v.regw));
      check("wb_pc_w_en", 32'(pc_w_en), 32'd1);
      check("wb_jump_en", 32'(jump_en), 32'(v.jump));
      check("wb_dmem_req", 32'(dmem_req), 32'd0);
      if (!v.wsel_dc) check("wb_reg_w_sel", 32'(reg_w_sel), 32'(v.wsel));
      retire_check();
      @(negedge clk);
    end
    #1;
    check("next_fetch_state", 32'(state_dbg), 32'(ST_FETCH));
    check_instret("instret_after_instr");
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; instr = 32'd0;
    exp_instret = 32'd0;

    //                instr         idly ddly kind     wsel   imm     rimm rs1pc regw jump wdc  idc
    vecs.push_back('{32'h00500093, 1, 0, K_WB,    2'b01, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}); // addi
    vecs.push_back('{32'h0000A103, 0, 3, K_LOAD,  2'b00, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}); // lw
    vecs.push_back('{32'h0020A023, 2, 1, K_STORE, 2'b00, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // sw
    vecs.push_back('{32'h008000EF, 0, 0, K_WB,    2'b10, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}); // jal
    vecs.push_back('{32'h00208463, 1, 0, K_BR,    2'b00, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}); // beq
    vecs.push_back('{32'h002081B3, 0, 0, K_WB,    2'b01, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}); // add
    vecs.push_back('{32'h123450B7, 3, 0, K_WB,    2'b01, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}); // lui
    vecs.push_back('{32'h00001097, 0, 0, K_WB,    2'b01, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}); // auipc
    vecs.push_back('{32'h000080E7, 1, 0, K_WB,    2'b10, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}); // jalr
    vecs.push_back('{32'h00500093, 4, 0, K_WB,    2'b01, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}); // imem ack at limit
    vecs.push_back('{32'h0000A103, 0, 4, K_LOAD,  2'b00, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}); // dmem ack at limit
`ifndef CTRL_ILLEGAL_TRAP_EN
    vecs.push_back('{32'h0000007F, 0, 0, K_WB,    2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}); // unknown -> NOP
`endif

    // Reset values while rst is held
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 32'(state_dbg), 32'(ST_FETCH));
    check("reset_imem_req", 32'(imem_req), 32'd0);
    check("reset_dmem_req", 32'(dmem_req), 32'd0);
    check("reset_strobes", 32'({ir_w_en, pc_w_en, reg_w_en, jump_en, branch_en, dmem_w_en}), 32'd0);
    check("reset_selects", 32'({reg_w_sel, reg_imm_sel, imm_sel, rs1_pc_sel}), 32'd0);
    check("reset_trap", 32'({trap, trap_cause}), 32'd0);
    check("reset_instret", instret, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // imem never acks: trap cause 01, instret frozen, late ack ignored
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("imem_to_wait_state", 32'(state_dbg), 32'(ST_FETCH));
      check("imem_to_no_trap_yet", 32'(trap), 32'd0);
      @(negedge clk);
    end
    #1;
    check("imem_to_trap", 32'(trap), 32'd1);
    check("imem_to_cause", 32'(trap_cause), 32'd1);
    check("imem_to_req_low", 32'(imem_req), 32'd0);
    check("imem_to_state", 32'(state_dbg), 32'(ST_TRAP));
    imem_ack = 1'b1;
    @(negedge clk); #1;
    check("trap_sticky", 32'(trap), 32'd1);
    check("trap_ir_w_en", 32'(ir_w_en), 32'd0);
    check("trap_instret_frozen", instret, exp_instret);
    imem_ack = 1'b0;
    do_reset();

    // dmem never acks on a load: trap cause 10
    drive_fetch(32'h0000A103);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("dmem_to_wait_state", 32'(state_dbg), 32'(ST_MEM));
      check("dmem_to_req", 32'(dmem_req), 32'd1);
      @(negedge clk);
    end
    #1;
    check("dmem_to_trap", 32'(trap), 32'd1);
    check("dmem_to_cause", 32'(trap_cause), 32'd2);
    check("dmem_to_req_low", 32'(dmem_req), 32'd0);
    check("dmem_to_instret", instret, 32'd0);
    do_reset();

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Unknown opcode traps from DECODE
    drive_fetch(32'h0000007F);
    #1;
    check("illegal_decode_state", 32'(state_dbg), 32'(ST_DECODE));
    @(negedge clk); #1;
    check("illegal_trap", 32'(trap), 32'd1);
    check("illegal_cause", 32'(trap_cause), 32'd3);
    check("illegal_instret", instret, 32'd0);
    do_reset();
`endif

    // Reset in MEM: request drops, no retire, stray dmem_ack afterwards ignored
    drive_fetch(32'h0020A023);
    @(negedge clk);
    @(negedge clk); #1;
    check("rstmem_in_mem", 32'(state_dbg), 32'(ST_MEM));
    rst = 1'b1;
    @(negedge clk); #1;
    check("rstmem_state", 32'(state_dbg), 32'(ST_FETCH));
    check("rstmem_dmem_req", 32'(dmem_req), 32'd0);
    check("rstmem_instret", instret, 32'd0);
    rst = 1'b0; dmem_ack = 1'b1; #1;
    check("rstmem_fresh_imem_req", 32'(imem_req), 32'd1);
    check("rstmem_stray_pc_w_en", 32'(pc_w_en), 32'd0);
    @(negedge clk);
    dmem_ack = 1'b0; #1;
    check("rstmem_stays_fetch", 32'(state_dbg), 32'(ST_FETCH));
    check("rstmem_instret_after", instret, 32'd0);
    exp_instret = 32'd0;
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
